// File: rtl/pe_issue_ctrl_if.sv
// Operand, PE and result signals between pe_issue_ctrl and its environment.
// The master modport is the controller; slave is the operand buffer, PE and result consumer.
interface pe_issue_ctrl_if #(
  parameter int LEN_W = 16
);
  logic             start;
  logic [LEN_W-1:0] len;
  logic [31:0]      init_acc;
  logic             op_valid;
  logic             op_ready;
  logic [31:0]      op_a;
  logic [31:0]      op_b;
  logic             pe_valid;
  logic [31:0]      pe_a;
  logic [31:0]      pe_b;
  logic [31:0]      pe_acc_in;
  logic [31:0]      pe_acc_out;
  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_data;
  logic             busy;

  modport master (
    input  start, len, init_acc, op_valid, op_a, op_b, pe_acc_out, res_ready,
    output op_ready, pe_valid, pe_a, pe_b, pe_acc_in, res_valid, res_data, busy
  );

  modport slave (
    output start, len, init_acc, op_valid, op_a, op_b, pe_acc_out, res_ready,
    input  op_ready, pe_valid, pe_a, pe_b, pe_acc_in, res_valid, res_data, busy
  );
endinterface

// File: rtl/pe_issue_ctrl.sv
// Issue controller for one pe_cell: feeds LEN operand pairs through the PE, threading the
// accumulator from pe_acc_out back to pe_acc_in, and returns the final accumulator.
package mp_types;
  typedef enum logic [1:0] {
    PREC_INT8 = 2'd0,
    PREC_FP16 = 2'd1,
    PREC_FP32 = 2'd2
  } prec_e;
endpackage

// state   | meaning
// IDLE    | waiting for start
// WAIT_OP | op_ready high, waiting for an operand pair
// WAIT_PE | pe_valid pulse issued, counting down PE latency
// RESULT  | res_valid high until res_ready
module pe_issue_ctrl #(
  parameter mp_types::prec_e PREC   = mp_types::PREC_INT8,
  parameter int              PE_LAT = 1,
  parameter int              LEN_W  = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  pe_issue_ctrl_if.master       bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_OP = 2'd1,
    S_WAIT_PE = 2'd2,
    S_RESULT  = 2'd3
  } state_e;

  localparam logic [3:0] LAT_INIT = 4'(PE_LAT);

  state_e           state, state_nxt;
  logic [LEN_W-1:0] len_reg;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] cnt_inc;
  logic [3:0]       lat_cnt;
  logic [31:0]      acc_reg;
  logic [31:0]      pe_a_reg;
  logic [31:0]      pe_b_reg;
  logic [31:0]      pe_acc_in_reg;
  logic             pe_valid_reg;
  logic             op_ready;
  logic             op_fire;
  logic             pe_done;
  logic             start_fire;

  function automatic logic [31:0] mask_op(input logic [31:0] x);
    logic [31:0] r;
    r = x;
    case (PREC)
      mp_types::PREC_INT8: r = {24'b0, x[7:0]};
      mp_types::PREC_FP16: r = {16'b0, x[15:0]};
      default:             r = x;
    endcase
    return r;
  endfunction

  // INT8 accumulates into a full 32-bit integer, so only FP16 narrows the accumulator.
  function automatic logic [31:0] mask_acc(input logic [31:0] x);
    logic [31:0] r;
    r = x;
    if (PREC == mp_types::PREC_FP16) r = {16'b0, x[15:0]};
    return r;
  endfunction

  assign cnt_inc    = cnt + LEN_W'(1);
  assign start_fire = (state == S_IDLE) && bus.start;
  assign op_fire    = (state == S_WAIT_OP) && bus.op_valid;
  assign pe_done    = (state == S_WAIT_PE) && (lat_cnt == 4'd0);

  always_ff @(posedge clk) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    op_ready  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.start) state_nxt = (bus.len == '0) ? S_RESULT : S_WAIT_OP;
      end
      S_WAIT_OP: begin
        op_ready = 1'b1;
        if (bus.op_valid) state_nxt = S_WAIT_PE;
      end
      S_WAIT_PE: begin
        if (lat_cnt == 4'd0) state_nxt = (cnt_inc == len_reg) ? S_RESULT : S_WAIT_OP;
      end
      S_RESULT: begin
        if (bus.res_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      len_reg       <= '0;
      cnt           <= '0;
      lat_cnt       <= 4'd0;
      acc_reg       <= 32'd0;
      pe_a_reg      <= 32'd0;
      pe_b_reg      <= 32'd0;
      pe_acc_in_reg <= 32'd0;
      pe_valid_reg  <= 1'b0;
    end else begin
      pe_valid_reg <= op_fire;

      if (start_fire) begin
        len_reg <= bus.len;
        acc_reg <= mask_acc(bus.init_acc);
        cnt     <= '0;
      end

      if (op_fire) begin
        pe_a_reg      <= mask_op(bus.op_a);
        pe_b_reg      <= mask_op(bus.op_b);
        pe_acc_in_reg <= acc_reg;
        lat_cnt       <= LAT_INIT;
      end else if ((state == S_WAIT_PE) && (lat_cnt != 4'd0)) begin
        lat_cnt <= lat_cnt - 4'd1;
      end

      // lat_cnt reaches zero in cycle t+PE_LAT, where t is the pe_valid cycle.
      if (pe_done) begin
        acc_reg <= mask_acc(bus.pe_acc_out);
        cnt     <= cnt_inc;
      end
    end
  end

  assign bus.op_ready  = op_ready;
  assign bus.pe_valid  = pe_valid_reg;
  assign bus.pe_a      = pe_a_reg;
  assign bus.pe_b      = pe_b_reg;
  assign bus.pe_acc_in = pe_acc_in_reg;
  assign bus.res_valid = (state == S_RESULT);
  assign bus.res_data  = (state == S_RESULT) ? acc_reg : 32'd0;
  assign bus.busy      = (state != S_IDLE);

endmodule

// File: tb/tb_pe_issue_ctrl.sv
// Directed bench for pe_issue_ctrl: an INT8/PE_LAT=1 instance and an FP32/PE_LAT=4 instance,
// each driven by a PE model that presents its result only in the cycle it is due.
module tb_pe_issue_ctrl;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;
  int   pulses0;
  int   w0;
  int   w1;
  logic [31:0] r0;
  logic [31:0] r1;

  pe_issue_ctrl_if #(.LEN_W(16)) b0 ();
  pe_issue_ctrl_if #(.LEN_W(16)) b1 ();

  pe_issue_ctrl #(.PREC(mp_types::PREC_INT8), .PE_LAT(1), .LEN_W(16)) u0 (
    .clk (clk),
    .rstn(rstn),
    .bus (b0)
  );

  pe_issue_ctrl #(.PREC(mp_types::PREC_FP32), .PE_LAT(4), .LEN_W(16)) u1 (
    .clk (clk),
    .rstn(rstn),
    .bus (b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Signed INT8 MAC model; the result is visible only in cycle t+PE_LAT, garbage otherwise.
  always @(negedge clk) begin
    if (b0.pe_valid) begin
      pulses0++;
      r0 = b0.pe_acc_in + 32'($signed(b0.pe_a[7:0]) * $signed(b0.pe_b[7:0]));
      w0 = 1;
    end else if (w0 >= 0) begin
      w0--;
    end
    b0.pe_acc_out = (w0 == 0) ? r0 : 32'hDEAD_BEEF;
  end

  // FP32 model knows one product: 0.5 + 1.0 * 2.0 = 2.5.
  always @(negedge clk) begin
    if (b1.pe_valid) begin
      r1 = (b1.pe_a == 32'h3F80_0000 && b1.pe_b == 32'h4000_0000 && b1.pe_acc_in == 32'h3F00_0000)
           ? 32'h4020_0000 : 32'hBAD0_BAD0;
      w1 = 4;
    end else if (w1 >= 0) begin
      w1--;
    end
    b1.pe_acc_out = (w1 == 0) ? r1 : 32'hDEAD_BEEF;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start0(input logic [15:0] len, input logic [31:0] init);
    b0.start    = 1'b1;
    b0.len      = len;
    b0.init_acc = init;
    tick();
    b0.start    = 1'b0;
  endtask

  task automatic send0(input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    b0.op_valid = 1'b1;
    b0.op_a     = a;
    b0.op_b     = b;
    while (!b0.op_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL send0_timeout: op_ready never rose, waited %0d cycles, required < 50", n);
    end
    tick();
    b0.op_valid = 1'b0;
  endtask

  task automatic wait_res0(output int n);
    n = 0;
    while (!b0.res_valid && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL wait_res0_timeout: res_valid never rose within %0d cycles", n);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    tick();
    tick();
    checks++;
    if ({b0.busy, b0.op_ready, b0.pe_valid, b0.res_valid} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl0: busy/op_ready/pe_valid/res_valid=%b required 0000",
               {b0.busy, b0.op_ready, b0.pe_valid, b0.res_valid});
    end
    checks++;
    if ({b0.res_data, b0.pe_a, b0.pe_b, b0.pe_acc_in} !== 128'd0) begin
      errors++;
      $display("FAIL reset_data0: res_data=%h pe_a=%h pe_b=%h pe_acc_in=%h required all 0",
               b0.res_data, b0.pe_a, b0.pe_b, b0.pe_acc_in);
    end
    checks++;
    if ({b1.busy, b1.op_ready, b1.pe_valid, b1.res_valid} !== 4'b0000 || b1.res_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_ctrl1: flags=%b res_data=%h required 0000 and 0",
               {b1.busy, b1.op_ready, b1.pe_valid, b1.res_valid}, b1.res_data);
    end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_int8_dot();
    int n;
    pulses0 = 0;
    start0(16'd3, 32'd10);
    checks++;
    if (b0.busy !== 1'b1 || b0.op_ready !== 1'b1) begin
      errors++;
      $display("FAIL int8_after_start: busy=%b op_ready=%b required 1 1", b0.busy, b0.op_ready);
    end
    send0(32'd2, 32'd3);
    send0(32'd4, 32'd5);
    send0(32'hFFFF_FFFF, 32'd7);
    checks++;
    if (b0.pe_valid !== 1'b1 || b0.pe_a !== 32'h0000_00FF || b0.pe_acc_in !== 32'd36) begin
      errors++;
      $display("FAIL int8_issue3: pe_valid=%b pe_a=%h pe_acc_in=%0d required 1 000000ff 36",
               b0.pe_valid, b0.pe_a, b0.pe_acc_in);
    end
    wait_res0(n);
    checks++;
    if (b0.res_data !== 32'd29) begin
      errors++;
      $display("FAIL int8_result: res_data=%0d required 29", b0.res_data);
    end
    checks++;
    if (pulses0 !== 3) begin
      errors++;
      $display("FAIL int8_pulses: pe_valid pulses=%0d required 3", pulses0);
    end
    b0.res_ready = 1'b1;
    tick();
    b0.res_ready = 1'b0;
    checks++;
    if (b0.res_valid !== 1'b0 || b0.busy !== 1'b0) begin
      errors++;
      $display("FAIL int8_release: res_valid=%b busy=%b required 0 0", b0.res_valid, b0.busy);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    pulses0 = 0;
    start0(16'd2, 32'd5);
    b0.op_valid = 1'b1;
    b0.op_a     = 32'd1;
    b0.op_b     = 32'd1;
    wait_res0(n);
    b0.op_valid = 1'b0;
    checks++;
    if (n !== 6) begin
      errors++;
      $display("FAIL b2b_latency: cycles to res_valid=%0d required 6", n);
    end
    checks++;
    if (b0.res_data !== 32'd7 || pulses0 !== 2) begin
      errors++;
      $display("FAIL b2b_result: res_data=%0d pulses=%0d required 7 2", b0.res_data, pulses0);
    end
    b0.res_ready = 1'b1;
    tick();
    b0.res_ready = 1'b0;
  endtask

  task automatic test_len_zero_and_hold();
    pulses0 = 0;
    start0(16'd0, 32'h0000_1234);
    checks++;
    if (b0.res_valid !== 1'b1 || b0.res_data !== 32'h0000_1234) begin
      errors++;
      $display("FAIL len0_result: res_valid=%b res_data=%h required 1 00001234",
               b0.res_valid, b0.res_data);
    end
    b0.start    = 1'b1;
    b0.len      = 16'd7;
    b0.init_acc = 32'h55;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (b0.res_valid !== 1'b1 || b0.res_data !== 32'h0000_1234 || b0.busy !== 1'b1) begin
        errors++;
        $display("FAIL hold_cycle%0d: res_valid=%b res_data=%h busy=%b required 1 00001234 1",
                 i, b0.res_valid, b0.res_data, b0.busy);
      end
    end
    b0.res_ready = 1'b1;
    tick();
    b0.start     = 1'b0;
    b0.res_ready = 1'b0;
    checks++;
    if (b0.busy !== 1'b0 || b0.res_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_exit_start_ignored: busy=%b res_valid=%b required 0 0",
               b0.busy, b0.res_valid);
    end
    tick();
    checks++;
    if (b0.busy !== 1'b0 || pulses0 !== 0) begin
      errors++;
      $display("FAIL len0_idle: busy=%b pulses=%0d required 0 0", b0.busy, pulses0);
    end
  endtask

  task automatic test_gaps_midop_start();
    int n;
    logic [31:0] pa [2];
    logic [31:0] pb [2];
    pa[0] = 32'd3;  pb[0] = 32'd4;
    pa[1] = 32'hFE; pb[1] = 32'd5;
    pulses0 = 0;
    start0(16'd2, 32'd100);
    for (int p = 0; p < 2; p++) begin
      b0.start    = 1'b1;
      b0.len      = 16'd9;
      b0.init_acc = 32'd999;
      for (int g = 0; g < 3; g++) begin
        checks++;
        if (b0.op_ready !== 1'b1 || b0.busy !== 1'b1) begin
          errors++;
          $display("FAIL gap_p%0d_g%0d: op_ready=%b busy=%b required 1 1", p, g, b0.op_ready, b0.busy);
        end
        tick();
      end
      b0.start = 1'b0;
      send0(pa[p], pb[p]);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (b0.op_ready !== 1'b0) begin
          errors++;
          $display("FAIL wait_pe_ready_p%0d_k%0d: op_ready=%b required 0", p, k, b0.op_ready);
        end
        if (k == 0) tick();
      end
      if (p == 0) tick();
    end
    wait_res0(n);
    checks++;
    if (b0.res_data !== 32'd102 || pulses0 !== 2) begin
      errors++;
      $display("FAIL gaps_result: res_data=%0d pulses=%0d required 102 2", b0.res_data, pulses0);
    end
    b0.res_ready = 1'b1;
    tick();
    b0.res_ready = 1'b0;
  endtask

  task automatic test_fp32_latency();
    int n;
    b1.start    = 1'b1;
    b1.len      = 16'd1;
    b1.init_acc = 32'h3F00_0000;
    tick();
    b1.start    = 1'b0;
    b1.op_valid = 1'b1;
    b1.op_a     = 32'h3F80_0000;
    b1.op_b     = 32'h4000_0000;
    n = 0;
    while (!b1.op_ready && n < 20) begin
      tick();
      n++;
    end
    tick();
    b1.op_valid = 1'b0;
    checks++;
    if (b1.pe_valid !== 1'b1 || b1.pe_a !== 32'h3F80_0000 || b1.pe_acc_in !== 32'h3F00_0000) begin
      errors++;
      $display("FAIL fp32_issue: pe_valid=%b pe_a=%h pe_acc_in=%h required 1 3f800000 3f000000",
               b1.pe_valid, b1.pe_a, b1.pe_acc_in);
    end
    n = 0;
    while (!b1.res_valid && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 5) begin
      errors++;
      $display("FAIL fp32_latency: cycles from pe_valid to res_valid=%0d required 5", n);
    end
    checks++;
    if (b1.res_data !== 32'h4020_0000) begin
      errors++;
      $display("FAIL fp32_result: res_data=%h required 40200000", b1.res_data);
    end
    b1.res_ready = 1'b1;
    tick();
    b1.res_ready = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    int n;
    start0(16'd1, 32'd1);
    send0(32'd2, 32'd2);
    checks++;
    if (b0.pe_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_setup: pe_valid=%b required 1", b0.pe_valid);
    end
    rstn = 1'b0;
    tick();
    checks++;
    if ({b0.busy, b0.op_ready, b0.pe_valid, b0.res_valid} !== 4'b0000 ||
        {b0.res_data, b0.pe_a, b0.pe_b, b0.pe_acc_in} !== 128'd0) begin
      errors++;
      $display("FAIL rst_midop: flags=%b res_data=%h pe_a=%h pe_b=%h pe_acc_in=%h required all 0",
               {b0.busy, b0.op_ready, b0.pe_valid, b0.res_valid},
               b0.res_data, b0.pe_a, b0.pe_b, b0.pe_acc_in);
    end
    rstn = 1'b1;
    tick();
    tick();
    checks++;
    if (b0.busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_stays_idle: busy=%b required 0", b0.busy);
    end
    start0(16'd1, 32'd3);
    send0(32'd4, 32'd5);
    wait_res0(n);
    checks++;
    if (b0.res_data !== 32'd23) begin
      errors++;
      $display("FAIL rst_fresh_result: res_data=%0d required 23", b0.res_data);
    end
    b0.res_ready = 1'b1;
    tick();
    b0.res_ready = 1'b0;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    pulses0 = 0;
    w0 = -1;
    w1 = -1;
    r0 = 32'd0;
    r1 = 32'd0;
    rstn = 1'b0;
    b0.start = 1'b0; b0.len = '0; b0.init_acc = 32'd0;
    b0.op_valid = 1'b0; b0.op_a = 32'd0; b0.op_b = 32'd0; b0.res_ready = 1'b0;
    b1.start = 1'b0; b1.len = '0; b1.init_acc = 32'd0;
    b1.op_valid = 1'b0; b1.op_a = 32'd0; b1.op_b = 32'd0; b1.res_ready = 1'b0;

    test_reset();
    test_int8_dot();
    test_back_to_back();
    test_len_zero_and_hold();
    test_gaps_midop_start();
    test_fp32_latency();
    test_reset_mid_op();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
